// File: rtl/core_debug_ctrl.sv
// Core-side debug controller: turns halt/resume/step requests into stall and
// redirect controls, records DPC/DCSR, and serves debug-module register accesses.
module core_debug_ctrl #(
    parameter bit RESET_HALT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enter_debug,
    input  logic        req_halt,
    input  logic        req_resume,
    input  logic        step,
    output logic        halted,
    output logic        running,
    output logic        stalled,
    input  logic        dm_req,
    input  logic        dm_write,
    input  logic [6:0]  dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_access_valid,
    output logic        core_stall,
    input  logic        pipe_empty,
    input  logic [31:0] next_pc,
    input  logic        retire_valid,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [4:0]  rf_addr,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED,
        ST_RESUME,
        ST_STEP
    } state_t;

    localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0] CAUSE_STEP    = 3'd4;
    localparam logic [6:0] ADDR_DPC      = 7'h20;
    localparam logic [6:0] ADDR_DCSR     = 7'h21;

    state_t      state, state_nxt;
    logic [2:0]  cause_pend, cause_pend_nxt;
    logic        step_first, step_first_nxt;
    logic [31:0] dpc, dpc_nxt;
    logic [2:0]  dcsr_cause, dcsr_cause_nxt;
    logic        dcsr_step, dcsr_step_nxt;

    logic        acc_ok;
    logic        is_gpr;
    logic        gpr_nz;
    logic [31:0] dcsr_val;
    logic [31:0] rdata_p0;
    logic [31:0] rdata_p1;
    logic        vld_p1;

    // Stage p0: access decode in the request cycle
    always_comb begin
        acc_ok   = dm_req && (state == ST_HALTED);
        is_gpr   = (dm_addr[6:5] == 2'b00);
        gpr_nz   = is_gpr && (dm_addr[4:0] != 5'd0);
        dcsr_val = {23'd0, dcsr_cause, 3'd0, dcsr_step, 2'd0};
        rf_addr  = dm_addr[4:0];
        rf_wdata = dm_wdata;
        rf_we    = acc_ok && dm_write && gpr_nz;
        rdata_p0 = '0;
        if (acc_ok && !dm_write) begin
            if (is_gpr) begin
                rdata_p0 = gpr_nz ? rf_rdata : 32'd0;
            end else if (dm_addr == ADDR_DPC) begin
                rdata_p0 = dpc;
            end else if (dm_addr == ADDR_DCSR) begin
                rdata_p0 = dcsr_val;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        cause_pend_nxt = cause_pend;
        step_first_nxt = 1'b0;
        dpc_nxt        = dpc;
        dcsr_cause_nxt = dcsr_cause;
        dcsr_step_nxt  = dcsr_step;

        case (state)
            ST_RUN: begin
                if (enter_debug) begin
                    state_nxt      = ST_DRAIN;
                    cause_pend_nxt = CAUSE_EBREAK;
                end else if (req_halt) begin
                    state_nxt      = ST_DRAIN;
                    cause_pend_nxt = CAUSE_HALTREQ;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_nxt      = ST_HALTED;
                    dpc_nxt        = next_pc;
                    dcsr_cause_nxt = cause_pend;
                end
            end
            ST_HALTED: begin
                // Step decision uses the DCSR value held before any same-cycle write
                if (req_resume) begin
                    if (step || dcsr_step) begin
                        state_nxt      = ST_STEP;
                        step_first_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_RESUME;
                    end
                end
            end
            ST_RESUME: begin
                state_nxt = ST_RUN;
            end
            ST_STEP: begin
                if (retire_valid) begin
                    state_nxt      = ST_DRAIN;
                    cause_pend_nxt = CAUSE_STEP;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        if (acc_ok && dm_write) begin
            if (dm_addr == ADDR_DPC) begin
                dpc_nxt = dm_wdata;
            end
            if (dm_addr == ADDR_DCSR) begin
                dcsr_step_nxt = dm_wdata[2];
            end
        end
    end

    always_comb begin
        halted         = (state == ST_HALTED);
        running        = (state == ST_RUN);
        stalled        = (state == ST_DRAIN) || (state == ST_RESUME) || (state == ST_STEP);
        redirect_valid = (state == ST_RESUME) || ((state == ST_STEP) && step_first);
        redirect_pc    = dpc;
        core_stall     = (state == ST_DRAIN) || (state == ST_HALTED) ||
                         ((state == ST_STEP) && !step_first);
    end

    // Stage p1: registered state and access completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RESET_HALT ? ST_DRAIN : ST_RUN;
            cause_pend <= RESET_HALT ? CAUSE_HALTREQ : 3'd0;
            step_first <= 1'b0;
            dpc        <= '0;
            dcsr_cause <= '0;
            dcsr_step  <= 1'b0;
            vld_p1     <= 1'b0;
            rdata_p1   <= '0;
        end else begin
            state      <= state_nxt;
            cause_pend <= cause_pend_nxt;
            step_first <= step_first_nxt;
            dpc        <= dpc_nxt;
            dcsr_cause <= dcsr_cause_nxt;
            dcsr_step  <= dcsr_step_nxt;
            vld_p1     <= dm_req;
            rdata_p1   <= rdata_p0;
        end
    end

    assign dm_access_valid = vld_p1;
    assign dm_rdata        = rdata_p1;

endmodule

// File: doc/core_debug_ctrl.md
# core_debug_ctrl

Processor-side debug controller in the core, directly downstream of the debug module's processor-facing debug signals. It turns halt, resume and single-step requests into pipeline stall and redirect controls, and records the halt PC (DPC) and cause (DCSR). While the hart is halted, it services debug-module register accesses to the GPR file, DPC and DCSR.

## Interface
Parameters:
- RESET_HALT, 0, when 1 the core enters debug directly out of reset (cause = 3).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- enter_debug  in  1  ebreak/trigger debug entry, level; cause = 1.
- req_halt  in  1  debug-module halt request, level; cause = 3.
- req_resume  in  1  resume request, single-cycle pulse.
- step  in  1  with req_resume: execute one instruction then re-halt.
- halted  out  1  high in HALTED only.
- running  out  1  high in RUN only.
- stalled  out  1  high in DRAIN, RESUME and STEP.
- dm_req  in  1  register-access strobe, single cycle.
- dm_write  in  1  1 = write, 0 = read.
- dm_addr  in  7  0x00–0x1F GPR x0–x31; 0x20 DPC; 0x21 DCSR.
- dm_wdata  in  32  write data.
- dm_rdata  out  32  read data, valid with dm_access_valid.
- dm_access_valid  out  1  access-complete pulse.
- core_stall  out  1  freeze fetch/issue.
- pipe_empty  in  1  no instruction in flight.
- next_pc  in  32  PC of the next unfetched instruction.
- retire_valid  in  1  one instruction retired this cycle.
- redirect_valid  out  1  fetch redirect pulse.
- redirect_pc  out  32  redirect target (= DPC).
- rf_addr  out  5  GPR port address.
- rf_we  out  1  GPR write enable.
- rf_wdata  out  32  GPR write data.
- rf_rdata  in  32  GPR read data, combinational from rf_addr.

## Operation
- States: RUN, DRAIN, HALTED, RESUME, STEP.
- **RUN**
  - core_stall = 0.
  - When enter_debug or req_halt is high: go to DRAIN and latch the cause. enter_debug takes priority (cause 1).
  - A req_resume pulse in RUN is ignored.
- **DRAIN**
  - core_stall = 1.
  - When pipe_empty is high: DPC ← next_pc, DCSR.cause[8:6] ← the latched cause, go to HALTED.
- **HALTED**
  - core_stall = 1.
  - On a req_resume pulse:
    - go to STEP if step = 1 or DCSR.step (bit 2) = 1;
    - otherwise go to RESUME.
- **RESUME**
  - One cycle: redirect_valid = 1, redirect_pc = DPC, core_stall = 0.
  - Next state is RUN.
- **STEP**
  - First cycle: redirect_valid = 1 and core_stall = 0, so exactly one instruction is fetched.
  - After that cycle: core_stall = 1 until retire_valid.
  - On retire_valid: go to DRAIN with cause = 4.
- **DCSR**
  - Bit 2 (step) is writable.
  - Bits 8:6 (cause) are read-only.
  - All other bits read 0.
- **Register accesses**
  - A dm_req accepted in HALTED completes with a dm_access_valid pulse on the next cycle.
  - GPR access: rf_addr = dm_addr[4:0] in the request cycle; rf_we = dm_write in the same cycle.
  - Reads register rf_rdata into dm_rdata.
  - Writes to x0 are dropped (rf_we stays 0); reads of x0 return 0.
  - DPC and DCSR reads and writes take effect in the request cycle.
  - Unmapped addresses: read 0, writes ignored.
  - A write completion returns dm_rdata = 0.
- **Boundary conditions**
  - dm_req outside HALTED: still acked next cycle, dm_rdata = 0, no side effects.
  - req_resume in the same cycle as dm_req: the access completes; the resume is taken in that same cycle, and the access writes land before the RESUME redirect.
  - New halt request in RESUME or STEP: held until the state returns to RUN, or to DRAIN for STEP.
  - Reset mid-operation: all state abandoned and registers reinitialised, with no pending redirect.

## Timing
- Reset values:
  - state = RUN; or DRAIN with cause 3 when RESET_HALT = 1.
  - DPC = 0; DCSR = 0.
  - dm_rdata = 0; dm_access_valid = 0.
  - redirect_valid = 0; rf_we = 0.
  - running = 1 and core_stall = 0; when RESET_HALT = 1, running = 0 and core_stall = 1.
- Latencies:
  - req_halt to core_stall: 1 cycle.
  - pipe_empty to halted: 1 cycle.
  - dm_req to dm_access_valid: 1 cycle.
  - req_resume to redirect_valid: 1 cycle.
- Outputs halted, running and stalled are decoded from registered state; they are one-hot or all-zero, never two asserted at once.
- Back-to-back dm_req is accepted every cycle.

## Test plan
- **Halt and drain**
  - Stimulus: req_halt high in RUN with pipe_empty = 0 for 3 cycles, next_pc = 0x8000_0040.
  - Required: core_stall rises the next cycle; halted rises 1 cycle after pipe_empty; DCSR read gives cause field = 3; DPC read gives 0x8000_0040.
- **GPR access**
  - Stimulus (halted): write x5 = 0xDEAD_BEEF, then read x5; write x0 = 1, then read x0.
  - Required: read x5 returns 0xDEAD_BEEF with dm_access_valid 1 cycle after dm_req; x0 write never asserts rf_we and x0 reads 0.
- **Resume**
  - Stimulus: write DPC = 0x100, then pulse req_resume.
  - Required: next cycle redirect_valid = 1 with redirect_pc = 0x100, then running = 1.
- **Single step**
  - Stimulus: req_resume with step = 1; retire_valid 4 cycles later.
  - Required: a single unstalled cycle; re-halt after drain with cause = 4 and DPC = the new next_pc.
- **Priority and out-of-state access**
  - Stimulus: enter_debug and req_halt together in RUN; then dm_req while in RUN.
  - Required: halt cause = 1; the RUN-state access is acked with dm_rdata = 0 and causes no write.
- **Reset behaviour**
  - Stimulus: reset asserted during STEP; also a run with RESET_HALT = 1.
  - Required: after reset in STEP, outputs return to reset values immediately; with RESET_HALT = 1, halted rises once pipe_empty, with cause = 3.
